// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared types and constants for the multicycle MIPS control FSM
//
// Purpose: state encodings, opcode/funct codes, ALU control words and
//          datapath mux select codes used by alu_decoder and mips_multicycle_ctrl.
// Ports:   none (package).
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BEQ    = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // {a_invert, b_invert, alu_op}
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - R-type funct field to ALU control word decoder
//
// Purpose: maps IR[5:0] to the ALU control word and flags whether the funct
//          is supported. Unsupported functs yield ADD with funct_legal=0.
// Ports:
//   funct       in  6  IR[5:0]
//   a_invert    out 1  ALU A-invert
//   b_invert    out 1  ALU B-invert
//   alu_op      out 2  ALU op select
//   funct_legal out 1  funct is one of ADD/SUB/AND/OR/SLT/NOR
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic       a_invert,
  output logic       b_invert,
  output logic [1:0] alu_op,
  output logic       funct_legal
);

  logic [3:0] cw;

  always_comb begin
    cw          = ALU_ADD;
    funct_legal = 1'b1;
    case (funct)
      FN_ADD:  cw = ALU_ADD;
      FN_SUB:  cw = ALU_SUB;
      FN_AND:  cw = ALU_AND;
      FN_OR:   cw = ALU_OR;
      FN_SLT:  cw = ALU_SLT;
      FN_NOR:  cw = ALU_NOR;
      default: funct_legal = 1'b0;
    endcase
  end

  assign {a_invert, b_invert, alu_op} = cw;

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - Moore main control FSM for the multicycle MIPS datapath
//
// Purpose: sequences fetch/decode/execute/memory/write-back and drives all
//          datapath enables, mux selects and the ALU control word.
// Optional feature: define MIPS_CTRL_BNE_EN to execute bne (opcode 0x05)
//          through the branch state with the zero test inverted; otherwise
//          0x05 is treated as illegal.
// Ports:
//   clk, rst                  clock (rising edge), synchronous active-high reset
//   opcode, funct             IR[31:26], IR[5:0]
//   zero                      ALU zero flag
//   pc_write, iord, mem_read, mem_write, ir_write,
//   reg_dst, mem_to_reg, reg_write, alu_src_a,
//   alu_src_b[1:0], pc_source[1:0]     datapath controls
//   a_invert, b_invert, alu_op[1:0]    ALU control word
//   retire                    pulse in the last state of each instruction
//   illegal                   pulse on unsupported opcode/funct or bad state
//   state[STATE_W-1:0]        current state (debug)
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  output logic               pc_write,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         pc_source,
  output logic               a_invert,
  output logic               b_invert,
  output logic [1:0]         alu_op,
  output logic               retire,
  output logic               illegal,
  output logic [STATE_W-1:0] state
);

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;
  logic [STATE_W-1:0] dec_next;
  logic               dec_illegal;
  logic               branch_take;
  logic [3:0]         fn_cw;
  logic               fn_legal;
  logic [3:0]         cw;

  alu_decoder u_alu_decoder (
    .funct       (funct),
    .a_invert    (fn_cw[3]),
    .b_invert    (fn_cw[2]),
    .alu_op      (fn_cw[1:0]),
    .funct_legal (fn_legal)
  );

  // Opcode dispatch out of DECODE; an illegal R-type funct is caught here so
  // EXEC is never entered for it.
  always_comb begin
    dec_next    = STATE_W'(S_FETCH);
    dec_illegal = 1'b0;
    case (opcode)
      OP_LW, OP_SW: dec_next = STATE_W'(S_MEMADR);
      OP_RTYPE: begin
        if (fn_legal) dec_next    = STATE_W'(S_EXEC);
        else          dec_illegal = 1'b1;
      end
      OP_BEQ:  dec_next = STATE_W'(S_BEQ);
`ifdef MIPS_CTRL_BNE_EN
      OP_BNE:  dec_next = STATE_W'(S_BEQ);
`endif
      OP_J:    dec_next = STATE_W'(S_JUMP);
      OP_ADDI: dec_next = STATE_W'(S_ADDIEX);
      default: dec_illegal = 1'b1;
    endcase
  end

`ifdef MIPS_CTRL_BNE_EN
  assign branch_take = (opcode == OP_BNE) ? ~zero : zero;
`else
  assign branch_take = zero;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= STATE_W'(S_FETCH);
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = STATE_W'(S_FETCH);
    case (state_q)
      STATE_W'(S_FETCH):  state_d = STATE_W'(S_DECODE);
      STATE_W'(S_DECODE): state_d = dec_next;
      STATE_W'(S_MEMADR): state_d = (opcode == OP_LW) ? STATE_W'(S_MEMRD) : STATE_W'(S_MEMWR);
      STATE_W'(S_MEMRD):  state_d = STATE_W'(S_MEMWB);
      STATE_W'(S_EXEC):   state_d = STATE_W'(S_RWB);
      STATE_W'(S_ADDIEX): state_d = STATE_W'(S_ADDIWB);
      default:            state_d = STATE_W'(S_FETCH);
    endcase
  end

  // Reset overrides every state so nothing is written while rst is held.
  always_comb begin
    pc_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_B;
    pc_source  = PCSRC_ALU;
    cw         = ALU_ADD;
    retire     = 1'b0;
    illegal    = 1'b0;
    if (!rst) begin
      case (state_q)
        STATE_W'(S_FETCH): begin
          mem_read  = 1'b1;
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          alu_src_b = SRCB_FOUR;
        end
        STATE_W'(S_DECODE): begin
          alu_src_b = SRCB_IMMSH2;
          illegal   = dec_illegal;
          retire    = dec_illegal;
        end
        STATE_W'(S_MEMADR), STATE_W'(S_ADDIEX): begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
        end
        STATE_W'(S_MEMRD): begin
          mem_read = 1'b1;
          iord     = 1'b1;
        end
        STATE_W'(S_MEMWB): begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          retire     = 1'b1;
        end
        STATE_W'(S_MEMWR): begin
          mem_write = 1'b1;
          iord      = 1'b1;
          retire    = 1'b1;
        end
        STATE_W'(S_EXEC): begin
          alu_src_a = 1'b1;
          cw        = fn_cw;
        end
        STATE_W'(S_RWB): begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
          retire    = 1'b1;
        end
        STATE_W'(S_ADDIWB): begin
          reg_write = 1'b1;
          retire    = 1'b1;
        end
        STATE_W'(S_BEQ): begin
          alu_src_a = 1'b1;
          cw        = ALU_SUB;
          pc_source = PCSRC_ALUOUT;
          pc_write  = branch_take;
          retire    = 1'b1;
        end
        STATE_W'(S_JUMP): begin
          pc_source = PCSRC_JUMP;
          pc_write  = 1'b1;
          retire    = 1'b1;
        end
        default: illegal = 1'b1;
      endcase
    end
  end

  assign {a_invert, b_invert, alu_op} = cw;
  assign state = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - self-checking bench for mips_multicycle_ctrl
module tb_mips_multicycle_ctrl;

  typedef struct packed {
    logic [3:0] st;
    logic       pc_write, iord, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, src_a;
    logic [1:0] src_b, pc_source;
    logic [3:0] cw;
    logic       retire, illegal;
  } step_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode, funct;
  logic       zero;
  logic       pc_write, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
  logic       alu_src_a, a_invert, b_invert, retire, illegal;
  logic [1:0] alu_src_b, pc_source, alu_op;
  logic [3:0] state;

  int n_checks = 0;
  int n_pass   = 0;
  step_t exp_q[$];

  mips_multicycle_ctrl #(.STATE_W(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .pc_write(pc_write), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .pc_source(pc_source), .a_invert(a_invert), .b_invert(b_invert),
    .alu_op(alu_op), .retire(retire), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic step_t obs();
    step_t t;
    t.st = state; t.pc_write = pc_write; t.iord = iord; t.mem_read = mem_read;
    t.mem_write = mem_write; t.ir_write = ir_write; t.reg_dst = reg_dst;
    t.mem_to_reg = mem_to_reg; t.reg_write = reg_write; t.src_a = alu_src_a;
    t.src_b = alu_src_b; t.pc_source = pc_source; t.cw = {a_invert, b_invert, alu_op};
    t.retire = retire; t.illegal = illegal;
    return t;
  endfunction

  function automatic step_t base(input logic [3:0] s);
    step_t t = '0;
    t.st = s;
    t.cw = 4'b0010;
    return t;
  endfunction

  // Reference: an instruction is expanded into the list of cycles it should take.
  task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z);
    logic [5:0] fns[6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27};
    logic [3:0] cws[6] = '{4'd2, 4'd6, 4'd0, 4'd1, 4'd7, 4'd12};
    step_t t;
    int    fidx = -1;
    bit    bne_ok = 1'b0;
`ifdef MIPS_CTRL_BNE_EN
    bne_ok = 1'b1;
`endif
    for (int i = 0; i < 6; i++) if (fns[i] == fn) fidx = i;
    exp_q.delete();
    t = base(0); t.mem_read = 1; t.ir_write = 1; t.pc_write = 1; t.src_b = 2'b01;
    exp_q.push_back(t);
    t = base(1); t.src_b = 2'b11;
    if (op == 6'h23 || op == 6'h2B) begin
      exp_q.push_back(t);
      t = base(2); t.src_a = 1; t.src_b = 2'b10; exp_q.push_back(t);
      if (op == 6'h23) begin
        t = base(3); t.mem_read = 1; t.iord = 1; exp_q.push_back(t);
        t = base(4); t.reg_write = 1; t.mem_to_reg = 1; t.retire = 1; exp_q.push_back(t);
      end else begin
        t = base(5); t.mem_write = 1; t.iord = 1; t.retire = 1; exp_q.push_back(t);
      end
    end else if (op == 6'h00 && fidx >= 0) begin
      exp_q.push_back(t);
      t = base(6); t.src_a = 1; t.cw = cws[fidx]; exp_q.push_back(t);
      t = base(7); t.reg_write = 1; t.reg_dst = 1; t.retire = 1; exp_q.push_back(t);
    end else if (op == 6'h04 || (op == 6'h05 && bne_ok)) begin
      exp_q.push_back(t);
      t = base(8); t.src_a = 1; t.cw = 4'd6; t.pc_source = 2'b01; t.retire = 1;
      t.pc_write = (op == 6'h04) ? z : !z;
      exp_q.push_back(t);
    end else if (op == 6'h02) begin
      exp_q.push_back(t);
      t = base(9); t.pc_source = 2'b10; t.pc_write = 1; t.retire = 1; exp_q.push_back(t);
    end else if (op == 6'h08) begin
      exp_q.push_back(t);
      t = base(10); t.src_a = 1; t.src_b = 2'b10; exp_q.push_back(t);
      t = base(11); t.reg_write = 1; t.retire = 1; exp_q.push_back(t);
    end else begin
      t.illegal = 1; t.retire = 1; exp_q.push_back(t);
    end
  endtask

  // Entered just after a falling edge with the DUT in FETCH; runs up to max_steps
  // cycles and returns just after a falling edge.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int max_steps);
    build(op, fn, z);
    opcode = op; funct = fn; zero = z;
    for (int i = 0; i < exp_q.size() && i < max_steps; i++) begin
      #1 check($sformatf("op%02h fn%02h z%0d cyc%0d", op, fn, z, i + 1), obs(), exp_q[i]);
      @(negedge clk);
    end
  endtask

  initial begin
    logic [5:0] ops[8] = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h02, 6'h08, 6'h05, 6'h00};
    logic [5:0] fnl[6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27};
    logic [5:0] op, fn;
    rst = 1'b1; opcode = 6'h23; funct = 6'h00; zero = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1 check("reset_hold", obs(), base(0));
    end
    rst = 1'b0;

    run_instr(6'h23, 6'h00, 1'b0, 99);
    run_instr(6'h00, 6'h22, 1'b0, 99);
    run_instr(6'h00, 6'h2A, 1'b1, 99);
    run_instr(6'h00, 6'h27, 1'b0, 99);
    run_instr(6'h04, 6'h00, 1'b1, 99);
    run_instr(6'h04, 6'h00, 1'b0, 99);
    run_instr(6'h2B, 6'h00, 1'b0, 99);
    run_instr(6'h3F, 6'h00, 1'b0, 99);
    run_instr(6'h00, 6'h01, 1'b0, 99);
    run_instr(6'h05, 6'h00, 1'b0, 99);
    run_instr(6'h02, 6'h11, 1'b0, 99);
    run_instr(6'h08, 6'h00, 1'b1, 99);

    // Reset while in MEMRD abandons the load.
    run_instr(6'h23, 6'h00, 1'b0, 3);
    #1 check("memrd_before_rst", obs(), exp_q[3]);
    rst = 1'b1;
    #1 check("rst_in_memrd", obs(), base(3));
    @(negedge clk);
    #1 check("rst_to_fetch", obs(), base(0));
    rst = 1'b0;

    for (int k = 0; k < 200; k++) begin
      op = ops[$urandom_range(0, 7)];
      fn = fnl[$urandom_range(0, 5)];
      if ($urandom_range(0, 7) == 0) op = 6'($urandom);
      if ($urandom_range(0, 5) == 0) fn = 6'($urandom);
      run_instr(op, fn, 1'($urandom), 99);
    end

    build(6'h00, 6'h20, 1'b0);
    #1 check("final_fetch", obs(), exp_q[0]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
